apb_initiator1: RTL and testbench

APB_INITIATOR1 -- requirements
Module: apb_initiator1

---
 rtl/apb_initiator1.sv | 125 ++++++++++++
 tb/tb_apb_initiator1.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator1.sv
// Single-outstanding APB initiator: one request -> SETUP -> ACCESS, with optional wait-state timeout.
// States: IDLE | ready for a request;  SETUP | psel up, address phase;  ACCESS | penable up, waiting on pready1
module apb_initiator1 #(
  parameter int TIMEOUT1 = 16
) (
  input  logic        pclk1,
  input  logic        n_p_reset1,
  input  logic        req_valid1,
  output logic        req_ready1,
  input  logic        req_write1,
  input  logic [7:0]  req_addr1,
  input  logic [31:0] req_wdata1,
  output logic        rsp_valid1,
  output logic [31:0] rsp_rdata1,
  output logic        rsp_err1,
  output logic        psel1,
  output logic        penable1,
  output logic        pwrite1,
  output logic [7:0]  paddr1,
  output logic [31:0] pwdata1,
  input  logic [31:0] prdata1,
  input  logic        pready1
);

  // TIMEOUT1 = 0 would give a zero-width counter, so keep at least one bit.
  localparam int CW = (TIMEOUT1 > 0) ? $clog2(TIMEOUT1 + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic          timeout_hit;
  logic          req_ready_n, psel_n, penable_n, pwrite_n;
  logic [7:0]    paddr_n;
  logic [31:0]   pwdata_n, rsp_rdata_n;
  logic          rsp_valid_n, rsp_err_n;

  assign timeout_hit = (TIMEOUT1 > 0) && (wcnt == TMO);

  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    psel_n      = psel1;
    penable_n   = penable1;
    pwrite_n    = pwrite1;
    paddr_n     = paddr1;
    pwdata_n    = pwdata1;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata1;
    rsp_err_n   = rsp_err1;
    case (state)
      IDLE: begin
        if (req_valid1) begin
          state_n   = SETUP;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          pwrite_n  = req_write1;
          paddr_n   = req_addr1;
          pwdata_n  = req_wdata1;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
        wcnt_n    = '0;
      end
      ACCESS: begin
        // pready1 wins over a timeout reached in the same cycle.
        if (pready1) begin
          state_n     = IDLE;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = pwrite1 ? 32'h0 : prdata1;
        end else if (timeout_hit) begin
          state_n     = IDLE;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = 32'h0;
        end else if (wcnt != '1) begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        psel_n    = 1'b0;
        penable_n = 1'b0;
      end
    endcase
    req_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge pclk1) begin
    if (!n_p_reset1) begin
      state      <= IDLE;
      wcnt       <= '0;
      req_ready1 <= 1'b1;
      psel1      <= 1'b0;
      penable1   <= 1'b0;
      pwrite1    <= 1'b0;
      paddr1     <= 8'h0;
      pwdata1    <= 32'h0;
      rsp_valid1 <= 1'b0;
      rsp_rdata1 <= 32'h0;
      rsp_err1   <= 1'b0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      req_ready1 <= req_ready_n;
      psel1      <= psel_n;
      penable1   <= penable_n;
      pwrite1    <= pwrite_n;
      paddr1     <= paddr_n;
      pwdata1    <= pwdata_n;
      rsp_valid1 <= rsp_valid_n;
      rsp_rdata1 <= rsp_rdata_n;
      rsp_err1   <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_apb_initiator1.sv
// Bench for apb_initiator1: per-scenario tasks with cycle-exact checks plus a response scoreboard.
module tb_apb_initiator1;

  logic        pclk1 = 1'b0;
  logic        n_p_reset1;
  logic        req_valid1, req_ready1, req_write1;
  logic [7:0]  req_addr1;
  logic [31:0] req_wdata1;
  logic        rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic        psel1, penable1, pwrite1;
  logic [7:0]  paddr1;
  logic [31:0] pwdata1, prdata1;
  logic        pready1;

  int n_cmp = 0;
  int n_mis = 0;
  int n_rsp = 0;
  bit mon_on = 1'b0;
  logic [32:0] sb_q[$];

  apb_initiator1 #(.TIMEOUT1(16)) dut (
    .pclk1(pclk1), .n_p_reset1(n_p_reset1),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_write1(req_write1),
    .req_addr1(req_addr1), .req_wdata1(req_wdata1),
    .rsp_valid1(rsp_valid1), .rsp_rdata1(rsp_rdata1), .rsp_err1(rsp_err1),
    .psel1(psel1), .penable1(penable1), .pwrite1(pwrite1),
    .paddr1(paddr1), .pwdata1(pwdata1), .prdata1(prdata1), .pready1(pready1)
  );

  always #5 pclk1 = ~pclk1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard pop on every response, plus the psel/penable protocol invariant.
  always @(negedge pclk1) begin
    if (mon_on) begin
      n_cmp++;
      if (penable1 && !psel1) begin
        n_mis++;
        $display("FAIL penable_without_psel: psel1=%b penable1=%b required psel1=1", psel1, penable1);
      end
      if (rsp_valid1) begin
        n_rsp++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_rsp: got err=%b rdata=%h, no response was expected", rsp_err1, rsp_rdata1);
        end else begin
          logic [32:0] exp;
          exp = sb_q.pop_front();
          if ({rsp_err1, rsp_rdata1} !== exp)
          begin
            n_mis++;
            $display("FAIL rsp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                     rsp_err1, rsp_rdata1, exp[32], exp[31:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge pclk1);
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    req_valid1 = 1'b1;
    req_write1 = wr;
    req_addr1  = addr;
    req_wdata1 = wdata;
  endtask

  task automatic test_reset();
    n_p_reset1 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({psel1, penable1, pwrite1, paddr1, pwdata1, rsp_valid1, rsp_rdata1, rsp_err1} !== 76'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rdata=%h err=%b required all 0",
               psel1, penable1, pwrite1, paddr1, pwdata1, rsp_valid1, rsp_rdata1, rsp_err1);
    end
    n_cmp++;
    if (req_ready1 !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_ready: got %b expected 1", req_ready1);
    end
    n_p_reset1 = 1'b1;
    mon_on = 1'b1;
    tick();
  endtask

  task automatic test_write();
    prdata1 = 32'hFFFF_0000;
    pready1 = 1'b1;
    n_cmp++;
    if (req_ready1 !== 1'b1) begin
      n_mis++;
      $display("FAIL wr_ready_idle: got %b expected 1", req_ready1);
    end
    issue(1'b1, 8'h1C, 32'hDEAD_BEEF);
    sb_q.push_back({1'b0, 32'h0});
    tick();
    req_valid1 = 1'b0;
    n_cmp++;
    if ({psel1, penable1, pwrite1, paddr1, pwdata1, req_ready1} !== {3'b101, 8'h1C, 32'hDEAD_BEEF, 1'b0}) begin
      n_mis++;
      $display("FAIL wr_setup: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rdy=%b required 1 0 1 1c deadbeef 0",
               psel1, penable1, pwrite1, paddr1, pwdata1, req_ready1);
    end
    tick();
    n_cmp++;
    if ({psel1, penable1, paddr1, pwdata1, rsp_valid1} !== {2'b11, 8'h1C, 32'hDEAD_BEEF, 1'b0}) begin
      n_mis++;
      $display("FAIL wr_access: psel=%b pen=%b paddr=%h pwdata=%h rv=%b required 1 1 1c deadbeef 0",
               psel1, penable1, paddr1, pwdata1, rsp_valid1);
    end
    tick();
    n_cmp++;
    if ({rsp_valid1, req_ready1, psel1, penable1} !== 4'b1100) begin
      n_mis++;
      $display("FAIL wr_done: rv=%b rdy=%b psel=%b pen=%b required 1 1 0 0",
               rsp_valid1, req_ready1, psel1, penable1);
    end
    tick();
    n_cmp++;
    if ({rsp_valid1, paddr1, pwdata1} !== {1'b0, 8'h1C, 32'hDEAD_BEEF}) begin
      n_mis++;
      $display("FAIL wr_after: rv=%b paddr=%h pwdata=%h required 0 1c deadbeef", rsp_valid1, paddr1, pwdata1);
    end
  endtask

  task automatic test_read_wait();
    prdata1 = 32'h0000_A5A5;
    pready1 = 1'b0;
    issue(1'b0, 8'h04, 32'h1234_5678);
    sb_q.push_back({1'b0, 32'h0000_A5A5});
    for (int c = 1; c <= 5; c++) begin
      tick();
      req_valid1 = 1'b0;
      n_cmp++;
      if (c < 5) begin
        if ({psel1, penable1, pwrite1, paddr1, rsp_valid1} !== {1'b1, (c > 1), 1'b0, 8'h04, 1'b0}) begin
          n_mis++;
          $display("FAIL rd_cycle%0d: psel=%b pen=%b pwr=%b paddr=%h rv=%b required 1 %b 0 04 0",
                   c, psel1, penable1, pwrite1, paddr1, rsp_valid1, (c > 1));
        end
      end else begin
        if ({rsp_valid1, rsp_rdata1, rsp_err1, paddr1} !== {1'b1, 32'h0000_A5A5, 1'b0, 8'h04}) begin
          n_mis++;
          $display("FAIL rd_done: rv=%b rdata=%h err=%b paddr=%h required 1 0000a5a5 0 04",
                   rsp_valid1, rsp_rdata1, rsp_err1, paddr1);
        end
      end
      if (c == 4) pready1 = 1'b1;
    end
    prdata1 = 32'h0BAD_0BAD;
    tick();
    n_cmp++;
    if ({rsp_valid1, rsp_rdata1} !== {1'b0, 32'h0000_A5A5}) begin
      n_mis++;
      $display("FAIL rd_hold: rv=%b rdata=%h required 0 0000a5a5", rsp_valid1, rsp_rdata1);
    end
  endtask

  // edge=1 raises pready1 on exactly the cycle the wait counter reaches the limit.
  task automatic test_timeout(input bit edge_case);
    logic [31:0] pd;
    pd = edge_case ? 32'hCAFE_0001 : 32'h1111_2222;
    prdata1 = pd;
    pready1 = 1'b0;
    issue(1'b0, 8'h80, 32'h0);
    sb_q.push_back(edge_case ? {1'b0, pd} : {1'b1, 32'h0});
    for (int c = 1; c <= 18; c++) begin
      tick();
      req_valid1 = 1'b0;
      n_cmp++;
      if ({psel1, rsp_valid1} !== 2'b10) begin
        n_mis++;
        $display("FAIL tmo_wait%0d_e%0d: psel=%b rv=%b required 1 0", c, edge_case, psel1, rsp_valid1);
      end
      if (c == 18 && edge_case) pready1 = 1'b1;
    end
    tick();
    n_cmp++;
    if ({rsp_valid1, rsp_err1, rsp_rdata1} !== {1'b1, ~edge_case, edge_case ? pd : 32'h0}) begin
      n_mis++;
      $display("FAIL tmo_done_e%0d: rv=%b err=%b rdata=%h required 1 %b %h",
               edge_case, rsp_valid1, rsp_err1, rsp_rdata1, ~edge_case, edge_case ? pd : 32'h0);
    end
    pready1 = 1'b1;
    tick();
    n_cmp++;
    if ({psel1, penable1, rsp_valid1, rsp_err1, req_ready1} !== {3'b000, ~edge_case, 1'b1}) begin
      n_mis++;
      $display("FAIL tmo_after_e%0d: psel=%b pen=%b rv=%b err=%b rdy=%b required 0 0 0 %b 1",
               edge_case, psel1, penable1, rsp_valid1, rsp_err1, req_ready1, ~edge_case);
    end
  endtask

  task automatic test_reset_abort();
    pready1 = 1'b0;
    prdata1 = 32'h7777_7777;
    issue(1'b1, 8'h33, 32'h5555_AAAA);
    tick();
    req_valid1 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({psel1, penable1} !== 2'b11) begin
      n_mis++;
      $display("FAIL abort_in_access: psel=%b pen=%b required 1 1", psel1, penable1);
    end
    n_p_reset1 = 1'b0;
    tick();
    n_cmp++;
    if ({psel1, penable1, pwrite1, paddr1, pwdata1, rsp_valid1, rsp_rdata1, rsp_err1} !== 76'h0) begin
      n_mis++;
      $display("FAIL abort_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rdata=%h err=%b required all 0",
               psel1, penable1, pwrite1, paddr1, pwdata1, rsp_valid1, rsp_rdata1, rsp_err1);
    end
    n_p_reset1 = 1'b1;
    pready1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({req_ready1, rsp_valid1, psel1} !== 3'b100) begin
        n_mis++;
        $display("FAIL abort_release%0d: rdy=%b rv=%b psel=%b required 1 0 0", c, req_ready1, rsp_valid1, psel1);
      end
    end
    // The aborted write owes no response.
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    int rsp_base;
    int accepts;
    logic wr;
    rsp_base = n_rsp;
    accepts = 0;
    pready1 = 1'b1;
    prdata1 = 32'h600D_0000;
    for (int i = 0; i <= 15; i++) begin
      n_cmp++;
      if ({req_ready1, psel1, penable1} !== {(i % 3 == 0), (i % 3 != 0), (i % 3 == 2)}) begin
        n_mis++;
        $display("FAIL b2b_phase%0d: rdy=%b psel=%b pen=%b required %b %b %b", i, req_ready1, psel1, penable1,
                 (i % 3 == 0), (i % 3 != 0), (i % 3 == 2));
      end
      n_cmp++;
      if (rsp_valid1 !== (i > 0 && i % 3 == 0)) begin
        n_mis++;
        $display("FAIL b2b_rv%0d: got %b expected %b", i, rsp_valid1, (i > 0 && i % 3 == 0));
      end
      if (i % 3 == 1) begin
        n_cmp++;
        if ({paddr1, pwdata1} !== {8'(8'h40 + i - 1), 32'hB0B0_0000 | 32'(i - 1)}) begin
          n_mis++;
          $display("FAIL b2b_addr%0d: paddr=%h pwdata=%h required %h %h", i, paddr1, pwdata1,
                   8'(8'h40 + i - 1), 32'hB0B0_0000 | 32'(i - 1));
        end
      end
      wr = (i % 2 == 1);
      req_valid1 = (i <= 12);
      req_write1 = wr;
      req_addr1  = 8'(8'h40 + i);
      req_wdata1 = 32'hB0B0_0000 | 32'(i);
      if (i % 3 == 0 && i <= 12) begin
        accepts++;
        sb_q.push_back({1'b0, wr ? 32'h0 : 32'h600D_0000});
      end
      tick();
    end
    req_valid1 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (n_rsp - rsp_base !== accepts) begin
      n_mis++;
      $display("FAIL b2b_rsp_count: got %0d expected %0d", n_rsp - rsp_base, accepts);
    end
  endtask

  initial begin
    n_p_reset1 = 1'b0;
    req_valid1 = 1'b0;
    req_write1 = 1'b0;
    req_addr1  = 8'h0;
    req_wdata1 = 32'h0;
    prdata1    = 32'h0;
    pready1    = 1'b1;
    tick();
    test_reset();
    test_write();
    test_read_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_abort();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_mis++;
      $display("FAIL sb_leftover: %0d responses still outstanding, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
